// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller: runs TLBP/TLBR/TLBWI/TLBWR against the TLB array
// and returns results to CP0 through single-cycle write-back strobes.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [1:0]    op_code,
    input  logic [31:0]   cp0_entryhi,
    input  logic [31:0]   cp0_entrylo0,
    input  logic [31:0]   cp0_entrylo1,
    input  logic [31:0]   cp0_index,
    output logic [IW-1:0] random,
    output logic          done,
    output logic          wb_index_we,
    output logic [31:0]   wb_index,
    output logic          wb_entry_we,
    output logic [31:0]   wb_entryhi,
    output logic [31:0]   wb_entrylo0,
    output logic [31:0]   wb_entrylo1,
    output logic [18:0]   s1_vpn2,
    output logic          s1_odd_page,
    output logic [7:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [18:0]   w_vpn2,
    output logic [7:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_pfn0,
    output logic [2:0]    w_c0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_pfn1,
    output logic [2:0]    w_c1,
    output logic          w_d1,
    output logic          w_v1,
    output logic [IW-1:0] r_index,
    input  logic [18:0]   r_vpn2,
    input  logic [7:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_pfn0,
    input  logic [2:0]    r_c0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_pfn1,
    input  logic [2:0]    r_c1,
    input  logic          r_d1,
    input  logic          r_v1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    state_t state, state_next;

    logic [1:0]    op_q;
    logic [18:0]   vpn2_q;
    logic [7:0]    asid_q;
    logic [25:0]   lo0_q;
    logic [25:0]   lo1_q;
    logic [IW-1:0] slot_q;
    logic [IW-1:0] rnd_q;
    logic          accept;

    logic unused_bits;
    assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26],
                           cp0_entrylo1[31:26], cp0_index[31:IW]};

    assign accept = op_valid && op_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_EXEC;
            S_EXEC:  state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready    = 1'b0;
        we          = 1'b0;
        done        = 1'b0;
        wb_index_we = 1'b0;
        wb_entry_we = 1'b0;
        case (state)
            S_IDLE: op_ready = 1'b1;
            S_EXEC: we = op_q[1];
            S_RESP: begin
                done        = 1'b1;
                wb_index_we = (op_q == OP_TLBP);
                wb_entry_we = (op_q == OP_TLBR);
            end
            default: ;
        endcase
    end

    // Random free-runs regardless of the FSM; TLBWR snapshots it at accept time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           rnd_q <= IW'(TLBNUM - 1);
        else if (rnd_q == '0)  rnd_q <= IW'(TLBNUM - 1);
        else                   rnd_q <= rnd_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= '0;
            vpn2_q <= '0;
            asid_q <= '0;
            lo0_q  <= '0;
            lo1_q  <= '0;
            slot_q <= '0;
        end else if (accept) begin
            op_q   <= op_code;
            vpn2_q <= cp0_entryhi[31:13];
            asid_q <= cp0_entryhi[7:0];
            lo0_q  <= cp0_entrylo0[25:0];
            lo1_q  <= cp0_entrylo1[25:0];
            slot_q <= (op_code == OP_TLBWR) ? rnd_q : cp0_index[IW-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_index    <= '0;
            wb_entryhi  <= '0;
            wb_entrylo0 <= '0;
            wb_entrylo1 <= '0;
        end else if (state == S_EXEC) begin
            if (op_q == OP_TLBP)
                wb_index <= {~s1_found, {(31-IW){1'b0}}, (s1_found ? s1_index : {IW{1'b0}})};
            if (op_q == OP_TLBR) begin
                wb_entryhi  <= {r_vpn2, 5'b0, r_asid};
                wb_entrylo0 <= {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g};
                wb_entrylo1 <= {6'b0, r_pfn1, r_c1, r_d1, r_v1, r_g};
            end
        end
    end

    assign random      = rnd_q;
    assign s1_vpn2     = vpn2_q;
    assign s1_asid     = asid_q;
    assign s1_odd_page = 1'b0;
    assign r_index     = slot_q;
    assign w_index     = slot_q;
    assign w_vpn2      = vpn2_q;
    assign w_asid      = asid_q;
    assign w_g         = lo0_q[0] & lo1_q[0];
    assign w_pfn0      = lo0_q[25:6];
    assign w_c0        = lo0_q[5:3];
    assign w_d0        = lo0_q[2];
    assign w_v0        = lo0_q[1];
    assign w_pfn1      = lo1_q[25:6];
    assign w_c1        = lo1_q[5:3];
    assign w_d1        = lo1_q[2];
    assign w_v1        = lo1_q[1];

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: a behavioural TLB array answers the DUT's ports, and an
// op-level reference model predicts every output on every cycle.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid, op_ready;
    logic [1:0]  op_code;
    logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index;
    logic [3:0]  random;
    logic        done, wb_index_we, wb_entry_we;
    logic [31:0] wb_index, wb_entryhi, wb_entrylo0, wb_entrylo1;
    logic [18:0] s1_vpn2;
    logic        s1_odd_page;
    logic [7:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index;
    logic        we;
    logic [3:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic        w_g;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0]  w_c0, w_c1;
    logic        w_d0, w_v0, w_d1, w_v1;
    logic [3:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        r_d0, r_v0, r_d1, r_v1;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
        .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index),
        .random(random), .done(done),
        .wb_index_we(wb_index_we), .wb_index(wb_index),
        .wb_entry_we(wb_entry_we), .wb_entryhi(wb_entryhi),
        .wb_entrylo0(wb_entrylo0), .wb_entrylo1(wb_entrylo1),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    always #5 clk = ~clk;

    int n_check = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Environment TLB array, driven only by the DUT's write port.
    logic [18:0] e_vpn2[16];
    logic [7:0]  e_asid[16];
    logic        e_g[16];
    logic [24:0] e_p0[16];
    logic [24:0] e_p1[16];

    always @(posedge clk) begin
        if (we) begin
            e_vpn2[w_index] <= w_vpn2;
            e_asid[w_index] <= w_asid;
            e_g[w_index]    <= w_g;
            e_p0[w_index]   <= {w_pfn0, w_c0, w_d0, w_v0};
            e_p1[w_index]   <= {w_pfn1, w_c1, w_d1, w_v1};
        end
    end

    always_comb begin
        s1_found = 1'b0;
        s1_index = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (e_vpn2[i] == s1_vpn2 && (e_g[i] || e_asid[i] == s1_asid)) begin
                s1_found = 1'b1;
                s1_index = 4'(i);
            end
        end
    end

    assign r_vpn2 = e_vpn2[r_index];
    assign r_asid = e_asid[r_index];
    assign r_g    = e_g[r_index];
    assign {r_pfn0, r_c0, r_d0, r_v0} = e_p0[r_index];
    assign {r_pfn1, r_c1, r_d1, r_v1} = e_p1[r_index];

    // Reference model: architectural TLB contents as CP0 words, op age since accept.
    logic [31:0] m_hi[16];
    logic [31:0] m_lo0[16];
    logic [31:0] m_lo1[16];
    logic        m_g[16];
    int          m_age;
    int          m_rand;
    logic [1:0]  m_op;
    logic [31:0] m_ehi, m_lo0_l, m_lo1_l;
    logic [3:0]  m_slot;
    logic [31:0] m_wbi, m_wbh, m_wbl0, m_wbl1;

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_hi[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0; m_g[i] = 0;
            e_vpn2[i] = 0; e_asid[i] = 0; e_g[i] = 0; e_p0[i] = 0; e_p1[i] = 0;
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_age = 0; m_rand = 15;
            m_wbi = 0; m_wbh = 0; m_wbl0 = 0; m_wbl1 = 0;
        end else begin
            if (m_age == 2) m_age = 0;
            else if (m_age == 1) begin
                case (m_op)
                    2'd0: begin
                        m_wbi = 32'h8000_0000;
                        for (int i = 15; i >= 0; i--)
                            if (m_hi[i][31:13] == m_ehi[31:13] &&
                                (m_g[i] || m_hi[i][7:0] == m_ehi[7:0]))
                                m_wbi = i;
                    end
                    2'd1: begin
                        m_wbh  = m_hi[m_slot];
                        m_wbl0 = m_lo0[m_slot] | 32'(m_g[m_slot]);
                        m_wbl1 = m_lo1[m_slot] | 32'(m_g[m_slot]);
                    end
                    default: begin
                        m_hi[m_slot]  = m_ehi & 32'hFFFF_E0FF;
                        m_lo0[m_slot] = m_lo0_l & 32'h03FF_FFFE;
                        m_lo1[m_slot] = m_lo1_l & 32'h03FF_FFFE;
                        m_g[m_slot]   = m_lo0_l[0] & m_lo1_l[0];
                    end
                endcase
                m_age = 2;
            end else if (op_valid) begin
                m_op    = op_code;
                m_ehi   = cp0_entryhi;
                m_lo0_l = cp0_entrylo0;
                m_lo1_l = cp0_entrylo1;
                m_slot  = (op_code == 2'd3) ? 4'(m_rand) : cp0_index[3:0];
                m_age   = 1;
            end
            m_rand = (m_rand + 15) % 16;
        end
    end

    always @(negedge clk) begin
        chk("op_ready", op_ready, m_age == 0);
        chk("random", random, m_rand);
        chk("we", we, m_age == 1 && m_op[1]);
        chk("done", done, m_age == 2);
        chk("wb_index_we", wb_index_we, m_age == 2 && m_op == 2'd0);
        chk("wb_entry_we", wb_entry_we, m_age == 2 && m_op == 2'd1);
        chk("wb_index", wb_index, m_wbi);
        chk("wb_entry", {wb_entryhi, wb_entrylo0, wb_entrylo1}, {m_wbh, m_wbl0, m_wbl1});
        if (m_age == 1 && m_op[1])
            chk("w_fields",
                {w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1},
                {m_slot, m_ehi[31:13], m_ehi[7:0], m_lo0_l[0] & m_lo1_l[0], m_lo0_l[25:1], m_lo1_l[25:1]});
        if (m_age == 1 && m_op == 2'd0)
            chk("s1_drive", {s1_vpn2, s1_asid, s1_odd_page}, {m_ehi[31:13], m_ehi[7:0], 1'b0});
        if (m_age == 1 && m_op == 2'd1)
            chk("r_index", r_index, m_slot);
    end

    task automatic reset_state_chk(input string tag);
        chk({tag, "_rdy_rand"}, {op_ready, random}, {1'b1, 4'hF});
        chk({tag, "_wb"}, {wb_index, wb_entryhi, wb_entrylo0, wb_entrylo1}, 128'd0);
        chk({tag, "_ctl"}, {done, we, wb_index_we, wb_entry_we, s1_vpn2, s1_asid, s1_odd_page,
                            w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                            w_pfn1, w_c1, w_d1, w_v1, r_index}, 128'd0);
    endtask

    // Issues one op; returns at the falling edge inside its EXEC cycle.
    task automatic do_op(input logic [1:0] code, input logic [31:0] hi, input logic [31:0] lo0,
                         input logic [31:0] lo1, input logic [31:0] idx);
        int n = 0;
        @(negedge clk);
        while (m_age != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            n_check++;
            $display("FAIL idle_wait: controller not idle after %0d cycles", n);
        end
        op_valid = 1'b1; op_code = code;
        cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1; cp0_index = idx;
        @(negedge clk);
        op_valid = 1'b0;
        cp0_entryhi = $urandom; cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom; cp0_index = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rdy;
        logic [31:0] hi;
        int          n;
        resetn = 1'b0; op_valid = 1'b0; op_code = 2'd0;
        cp0_entryhi = 0; cp0_entrylo0 = 0; cp0_entrylo1 = 0; cp0_index = 0;
        @(negedge clk);
        reset_state_chk("rst0");
        @(negedge clk);
        #2 resetn = 1'b1;
        #1 chk("t1_first_random", {op_ready, random, we, done}, {1'b1, 4'd15, 2'b00});
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("t1_random_seq", random, (31 - i) % 16);
        end

        do_op(2'd2, 32'h0040_2005, 32'h0000_101F, 32'h0000_105A, 32'd3);
        chk("t2_write", {we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_pfn1, w_d1},
            {1'b1, 4'd3, 19'h00201, 8'h05, 1'b0, 20'h00040, 3'd3, 1'b1, 20'h00041, 1'b0});
        @(negedge clk);
        chk("t2_we_one_cycle", we, 1'b0);

        do_op(2'd0, 32'h0040_2005, 0, 0, 0);
        @(negedge clk);
        chk("t3_probe_hit", {done, wb_index_we, wb_index}, {2'b11, 32'h0000_0003});
        do_op(2'd0, 32'h0040_2006, 0, 0, 0);
        @(negedge clk);
        chk("t3_probe_miss", {done, wb_index_we, wb_index}, {2'b11, 32'h8000_0000});

        do_op(2'd1, 0, 0, 0, 32'd3);
        @(negedge clk);
        chk("t4_read", {wb_entry_we, wb_entryhi, wb_entrylo0, wb_entrylo1},
            {1'b1, 32'h0040_2005, 32'h0000_101E, 32'h0000_105A});

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_rand == 9 && m_age == 0) && n < 40);
        op_valid = 1'b1; op_code = 2'd3;
        cp0_entryhi = 32'h00C0_4011; cp0_entrylo0 = 32'h0012_3457; cp0_entrylo1 = 32'h0012_3487;
        cp0_index = 32'd2;
        @(negedge clk);
        chk("t5_random_slot", {we, w_index, random}, {1'b1, 4'd9, 4'd8});
        rdy[2] = op_ready; op_code = 2'd0;
        @(negedge clk);
        rdy[1] = op_ready;
        @(negedge clk);
        rdy[0] = op_ready;
        @(negedge clk);
        op_valid = 1'b0;
        chk("t5_ready_gap", rdy, 3'b001);

        do_op(2'd2, 32'h1234_A0C1, 32'h0155_5557, 32'h02AA_AAAF, 32'd5);
        chk("t6_we_exec", we, 1'b1);
        #2 resetn = 1'b0;
        #1 chk("t6_we_async_drop", we, 1'b0);
        reset_state_chk("rst6");
        @(negedge clk);
        #2 resetn = 1'b1;
        do_op(2'd1, 0, 0, 0, 32'd5);
        @(negedge clk);
        chk("t6_entry_unchanged", {wb_entry_we, wb_entryhi, wb_entrylo0, wb_entrylo1}, {1'b1, 96'd0});

        for (int k = 0; k < 400; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            hi = $urandom;
            hi[31:16] = 16'h0040;
            hi[7:2] = 6'd0;
            do_op(2'($urandom_range(0, 3)), hi, $urandom, $urandom, $urandom);
        end
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
